// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Outputs come straight from flops; an empty or flushed stage presents a NOP bubble.
module pipe_stage_skid #(
  parameter int                 ADDR_W  = 32,
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  NOP_VAL = 32'h00000013,
  parameter int                 CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_r;
  logic                out_valid_r;
  logic                in_ready_r;
  logic [ADDR_W-1:0]   main_addr_r;
  logic [DATA_W-1:0]   main_data_r;
  logic [ADDR_W-1:0]   skid_addr_r;
  logic [DATA_W-1:0]   skid_data_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                accept_s;
  logic                drain_s;

  assign accept_s = in_valid_i & in_ready_r;
  assign drain_s  = out_valid_r & out_ready_i;

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign out_addr_o  = main_addr_r;
  assign out_data_o  = main_data_r;
  assign stall_cnt_o = stall_cnt_r;

  // Stage FSM: main/skid storage, handshake flags and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      main_addr_r <= {ADDR_W{1'b0}};
      main_data_r <= NOP_VAL;
      skid_addr_r <= {ADDR_W{1'b0}};
      skid_data_r <= NOP_VAL;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      // Counter keeps running through flushes; only rst clears it.
      if (out_valid_r && !out_ready_i && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end

      if (flush_i) begin
        state_r     <= ST_EMPTY;
        out_valid_r <= 1'b0;
        in_ready_r  <= 1'b1;
        main_addr_r <= {ADDR_W{1'b0}};
        main_data_r <= NOP_VAL;
        skid_addr_r <= {ADDR_W{1'b0}};
        skid_data_r <= NOP_VAL;
      end else begin
        case (state_r)
          ST_EMPTY: begin
            if (accept_s) begin
              state_r     <= ST_ONE;
              out_valid_r <= 1'b1;
              main_addr_r <= in_addr_i;
              main_data_r <= in_data_i;
            end else begin
              state_r     <= ST_EMPTY;
            end
          end
          ST_ONE: begin
            if (accept_s && drain_s) begin
              main_addr_r <= in_addr_i;
              main_data_r <= in_data_i;
            end else if (accept_s) begin
              state_r     <= ST_TWO;
              in_ready_r  <= 1'b0;
              skid_addr_r <= in_addr_i;
              skid_data_r <= in_data_i;
            end else if (drain_s) begin
              state_r     <= ST_EMPTY;
              out_valid_r <= 1'b0;
              main_addr_r <= {ADDR_W{1'b0}};
              main_data_r <= NOP_VAL;
            end else begin
              state_r     <= ST_ONE;
            end
          end
          ST_TWO: begin
            if (drain_s) begin
              state_r     <= ST_ONE;
              in_ready_r  <= 1'b1;
              main_addr_r <= skid_addr_r;
              main_data_r <= skid_data_r;
              skid_addr_r <= {ADDR_W{1'b0}};
              skid_data_r <= NOP_VAL;
            end else begin
              state_r     <= ST_TWO;
            end
          end
          default: begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            main_addr_r <= {ADDR_W{1'b0}};
            main_data_r <= NOP_VAL;
            skid_addr_r <= {ADDR_W{1'b0}};
            skid_data_r <= NOP_VAL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush,
// counter saturation (CNT_W=4) and reset mid-stream.
module tb_pipe_stage_skid;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.ADDR_W(AW), .DATA_W(DW), .NOP_VAL(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_addr_i(in_addr), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(out_addr), .out_data_o(out_data),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then settle past the edge.
  task automatic cyc(input logic v, input logic [31:0] a, input logic rdy,
                     input logic fl, input logic r);
    in_valid  = v;
    in_addr   = a;
    in_data   = 32'hD000_0000 | a;
    out_ready = rdy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_valid"}, 64'(out_valid), 64'(v));
    check({tag, "_addr"},  64'(out_addr),  64'(a));
    check({tag, "_data"},  64'(out_data),  64'(d));
  endtask

  initial begin
    // 1. Reset then idle
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_out("rst", 1'b0, 32'h0, NOP);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk_out($sformatf("idle%0d", k), 1'b0, 32'h0, NOP);
      check($sformatf("idle%0d_ready", k), 64'(in_ready), 64'd1);
    end

    // 2. Streaming with downstream always ready
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 32'(k * 4), 1'b1, 1'b0, 1'b0);
      chk_out($sformatf("stream%0d", k), 1'b1, 32'(k * 4), 32'hD000_0000 | 32'(k * 4));
      check($sformatf("stream%0d_ready", k), 64'(in_ready), 64'd1);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk_out("stream_end", 1'b0, 32'h0, NOP);
    check("stream_stall", 64'(stall_cnt), 64'd0);

    // 3. Back-pressure: A then B fill both entries
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    chk_out("bp_a", 1'b1, 32'h100, 32'hD000_0100);
    check("bp_a_ready", 64'(in_ready), 64'd1);
    check("bp_a_stall", 64'(stall_cnt), 64'd0);
    cyc(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    chk_out("bp_b", 1'b1, 32'h100, 32'hD000_0100);
    check("bp_b_ready", 64'(in_ready), 64'd0);
    check("bp_b_stall", 64'(stall_cnt), 64'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("bp_hold_stall", 64'(stall_cnt), 64'd2);
    check("bp_hold_addr", 64'(out_addr), 64'h100);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk_out("bp_drain_a", 1'b1, 32'h104, 32'hD000_0104);
    check("bp_drain_a_ready", 64'(in_ready), 64'd1);
    check("bp_drain_a_stall", 64'(stall_cnt), 64'd2);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk_out("bp_drain_b", 1'b0, 32'h0, NOP);

    // 4. Flush while holding two entries, with a beat offered the same cycle
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
    check("fl_two_ready", 64'(in_ready), 64'd0);
    check("fl_two_stall", 64'(stall_cnt), 64'd3);
    cyc(1'b1, 32'h208, 1'b0, 1'b1, 1'b0);
    chk_out("fl", 1'b0, 32'h0, NOP);
    check("fl_ready", 64'(in_ready), 64'd1);
    check("fl_stall_kept", 64'(stall_cnt), 64'd4);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk_out("fl_after", 1'b0, 32'h0, NOP);
    // Beat accepted in a flush cycle is dropped
    cyc(1'b1, 32'h20C, 1'b1, 1'b1, 1'b0);
    chk_out("fl_accept_drop", 1'b0, 32'h0, NOP);

    // 5. Counter saturation
    cyc(1'b1, 32'h280, 1'b0, 1'b0, 1'b0);
    check("sat_start", 64'(stall_cnt), 64'd4);
    for (int k = 0; k < 20; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("sat_full", 64'(stall_cnt), 64'hF);
    chk_out("sat_held", 1'b1, 32'h280, 32'hD000_0280);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("sat_rst", 64'(stall_cnt), 64'd0);
    chk_out("sat_rst", 1'b0, 32'h0, NOP);

    // 6. Reset mid-stream in the two-entry state, then resume
    cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    check("r6_two_ready", 64'(in_ready), 64'd0);
    check("r6_two_stall", 64'(stall_cnt), 64'd1);
    cyc(1'b1, 32'h308, 1'b1, 1'b1, 1'b1);
    chk_out("r6_rst", 1'b0, 32'h0, NOP);
    check("r6_rst_ready", 64'(in_ready), 64'd1);
    check("r6_rst_stall", 64'(stall_cnt), 64'd0);
    cyc(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    chk_out("r6_k", 1'b1, 32'h400, 32'hD000_0400);
    cyc(1'b1, 32'h404, 1'b1, 1'b0, 1'b0);
    chk_out("r6_l", 1'b1, 32'h404, 32'hD000_0404);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk_out("r6_end", 1'b0, 32'h0, NOP);
    check("r6_end_stall", 64'(stall_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
